mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares one burst-capable memory port between the ICache refill path (read-only) and the
//  DCache refill/writeback path. Sits between the two cache miss engines and the AXI bridge.
//  Runs one transaction at a time: address phase, then read data or write data plus response.
//  DCache has fixed priority, with a starvation counter that forces an ICache grant.
// PARAMETERS
//  ADDR_W        32  address width
//  DATA_W        32  beat width
//  LEN_W          4  burst length field; value = beats-1 (1..16 beats)
//  STARVE_LIMIT   8  cycles a pending i_req may lose before it wins the next arbitration
// PORTS
//  clk          in   1       clock
//  reset        in   1       asynchronous, active-high reset
//  i_req        in   1       ICache read burst request (held until i_addr_ok)
//  i_addr       in   ADDR_W  ICache burst start address
//  i_len        in   LEN_W   ICache beats-1
//  i_addr_ok    out  1       1-cycle pulse: ICache request accepted downstream
//  i_rvalid     out  1       read beat valid for ICache
//  i_rlast      out  1       last ICache read beat
//  d_req        in   1       DCache request (held until d_addr_ok)
//  d_wr         in   1       1 = writeback burst, 0 = refill read
//  d_addr       in   ADDR_W  DCache burst start address
//  d_len        in   LEN_W   DCache beats-1
//  d_addr_ok    out  1       1-cycle pulse: DCache request accepted downstream
//  d_rvalid     out  1       read beat valid for DCache
//  d_rlast      out  1       last DCache read beat
//  d_wdata      in   DATA_W  write beat data
//  d_wvalid     in   1       write beat valid
//  d_wready     out  1       write beat accepted (= m_wready in WDATA)
//  d_bvalid     out  1       1-cycle pulse: write burst completed
//  rdata        out  DATA_W  read beat data, broadcast to both caches (= m_rdata)
//  m_req        out  1       downstream request (registered)
//  m_wr         out  1       downstream write flag (registered)
//  m_addr       out  ADDR_W  downstream address (registered)
//  m_len        out  LEN_W   downstream beats-1 (registered)
//  m_addr_ok    in   1       downstream address handshake
//  m_rvalid     in   1       downstream read beat valid
//  m_rlast      in   1       downstream last read beat
//  m_rdata      in   DATA_W  downstream read data
//  m_wdata      out  DATA_W  = d_wdata
//  m_wvalid     out  1       = d_wvalid in WDATA, else 0
//  m_wlast      out  1       beat count == latched len, in WDATA
//  m_wready     in   1       downstream write beat ready
//  m_bvalid     in   1       downstream write response
// BEHAVIOUR
//  Reset: state=IDLE, owner=none, starve_cnt=0, beat_cnt=0. All outputs are 0 except rdata and m_wdata, which pass through.
//  FSM: IDLE -> ADDR -> (RDATA | WDATA -> WRESP) -> IDLE.
//  IDLE arbitration:
//   - Only d_req: grant D. Only i_req: grant I.
//   - Both: grant I if starve_cnt >= STARVE_LIMIT, else grant D.
//   - On grant, latch owner/addr/len/wr (wr=0 for I) into the m_* registers. m_req=1 from the next cycle.
//  ADDR: hold m_* stable. On m_addr_ok, pulse the owner's *_addr_ok in the same cycle and deassert m_req.
//   - Go to WDATA if wr, else RDATA.
//  RDATA: forward m_rvalid/m_rlast to the owner only. On m_rvalid & m_rlast -> IDLE.
//  WDATA: beat_cnt counts m_wvalid & m_wready. When a beat with m_wlast is accepted -> WRESP and clear beat_cnt.
//  WRESP: on m_bvalid, pulse d_bvalid -> IDLE.
//  Turnaround: earliest new m_req is 2 cycles after the last beat or bvalid (IDLE cycle + grant register).
//  starve_cnt: +1 each cycle i_req=1 and owner!=I, saturating at STARVE_LIMIT. Cleared when I is granted.
//  Stray inputs: m_rvalid outside RDATA, m_bvalid outside WRESP and m_wready outside WDATA are ignored; no outputs toggle.
//  Requester inputs after *_addr_ok are don't-care; the latched values are used.
//  Reset asserted mid-burst: immediate return to reset state; the downstream port shares the reset.
// TESTING
//  T1 i_req alone, addr=0x1fc0_0000, len=7 -> m_req next cycle; i_addr_ok on m_addr_ok; 8 i_rvalid, i_rlast on 8th, d_rvalid stays 0.
//  T2 i_req and d_req in same cycle, d_wr=1, len=3 -> D granted first; 4 beats with m_wlast on 4th; d_bvalid; then I granted.
//  T3 d_req held continuously, i_req pending -> after starve_cnt reaches 8, I wins the next IDLE arbitration.
//  T4 m_wready toggling 1,0,1,0 during a 4-beat write -> beat_cnt advances only on accepted beats; m_wlast on 4th accepted beat.
//  T5 stray m_rvalid/m_bvalid pulses in IDLE -> no *_rvalid/d_bvalid output; state remains IDLE.
//  T6 reset asserted during RDATA beat 3 of 8 -> outputs 0 same cycle; after release a fresh d_req is granted normally.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two cache miss engines, the arbiter and the downstream memory bridge.
// The slave modport is the arbiter's view. The master modport is the view of the environment
// that drives the cache requests and the downstream responses.
interface mem_bus_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 4
);
  // ICache side
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [LEN_W-1:0]  i_len;
  logic              i_addr_ok;
  logic              i_rvalid;
  logic              i_rlast;
  // DCache side
  logic              d_req;
  logic              d_wr;
  logic [ADDR_W-1:0] d_addr;
  logic [LEN_W-1:0]  d_len;
  logic              d_addr_ok;
  logic              d_rvalid;
  logic              d_rlast;
  logic [DATA_W-1:0] d_wdata;
  logic              d_wvalid;
  logic              d_wready;
  logic              d_bvalid;
  logic [DATA_W-1:0] rdata;
  // Downstream side
  logic              m_req;
  logic              m_wr;
  logic [ADDR_W-1:0] m_addr;
  logic [LEN_W-1:0]  m_len;
  logic              m_addr_ok;
  logic              m_rvalid;
  logic              m_rlast;
  logic [DATA_W-1:0] m_rdata;
  logic [DATA_W-1:0] m_wdata;
  logic              m_wvalid;
  logic              m_wlast;
  logic              m_wready;
  logic              m_bvalid;

  modport slave (
    input  i_req, i_addr, i_len,
    output i_addr_ok, i_rvalid, i_rlast,
    input  d_req, d_wr, d_addr, d_len, d_wdata, d_wvalid,
    output d_addr_ok, d_rvalid, d_rlast, d_wready, d_bvalid, rdata,
    output m_req, m_wr, m_addr, m_len, m_wdata, m_wvalid, m_wlast,
    input  m_addr_ok, m_rvalid, m_rlast, m_rdata, m_wready, m_bvalid
  );

  modport master (
    output i_req, i_addr, i_len,
    input  i_addr_ok, i_rvalid, i_rlast,
    output d_req, d_wr, d_addr, d_len, d_wdata, d_wvalid,
    input  d_addr_ok, d_rvalid, d_rlast, d_wready, d_bvalid, rdata,
    input  m_req, m_wr, m_addr, m_len, m_wdata, m_wvalid, m_wlast,
    output m_addr_ok, m_rvalid, m_rlast, m_rdata, m_wready, m_bvalid
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one burst memory port between ICache refills and DCache refills/writebacks.
// One transaction at a time; DCache wins by default, and a starvation counter forces an
// ICache grant once it has lost for STARVE_LIMIT cycles.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned LEN_W        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input logic              clk,
  input logic              reset,
  mem_bus_arbiter_if.slave bus
);

  localparam int unsigned     StW       = $clog2(STARVE_LIMIT + 1);
  localparam logic [StW-1:0]  StarveMax = StW'(STARVE_LIMIT);

  typedef enum logic [2:0] {StIdle, StAddr, StRdata, StWdata, StWresp} state_e;
  typedef enum logic [1:0] {OwnNone, OwnI, OwnD} owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              m_req_q, m_req_d;
  logic              m_wr_q, m_wr_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [LEN_W-1:0]  m_len_q, m_len_d;
  logic [StW-1:0]    starve_q, starve_d;
  logic [LEN_W-1:0]  beat_q, beat_d;

  logic              grant_i;
  logic              wbeat_acc;
  logic              wlast;
  logic [DATA_W-1:0] wdata_fwd;

  // Arbitration and write-beat bookkeeping terms shared by both processes
  always_comb begin
    grant_i   = (state_q == StIdle) && bus.i_req && (!bus.d_req || (starve_q >= StarveMax));
    wlast     = (state_q == StWdata) && (beat_q == m_len_q);
    wbeat_acc = (state_q == StWdata) && bus.d_wvalid && bus.m_wready;
    wdata_fwd = bus.d_wdata;
  end

  // Next-state: FSM, latched request, beat counter and starvation counter
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    m_req_d  = m_req_q;
    m_wr_d   = m_wr_q;
    m_addr_d = m_addr_q;
    m_len_d  = m_len_q;
    beat_d   = beat_q;
    starve_d = starve_q;

    case (state_q)
      StIdle: begin
        if (bus.i_req || bus.d_req) begin
          state_d = StAddr;
          m_req_d = 1'b1;
          if (grant_i) begin
            owner_d  = OwnI;
            m_wr_d   = 1'b0;
            m_addr_d = bus.i_addr;
            m_len_d  = bus.i_len;
          end else begin
            owner_d  = OwnD;
            m_wr_d   = bus.d_wr;
            m_addr_d = bus.d_addr;
            m_len_d  = bus.d_len;
          end
        end
      end
      StAddr: begin
        if (bus.m_addr_ok) begin
          m_req_d = 1'b0;
          state_d = m_wr_q ? StWdata : StRdata;
        end
      end
      StRdata: begin
        if (bus.m_rvalid && bus.m_rlast) begin
          state_d = StIdle;
          owner_d = OwnNone;
        end
      end
      StWdata: begin
        if (wbeat_acc) begin
          if (wlast) begin
            beat_d  = '0;
            state_d = StWresp;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      StWresp: begin
        if (bus.m_bvalid) begin
          state_d = StIdle;
          owner_d = OwnNone;
        end
      end
      default: state_d = StIdle;
    endcase

    // Counts every cycle the ICache waits while someone else holds (or wins) the port
    if (grant_i) begin
      starve_d = '0;
    end else if (bus.i_req && (owner_q != OwnI) && (starve_q != StarveMax)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // State registers; the downstream port shares this reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      owner_q  <= OwnNone;
      m_req_q  <= 1'b0;
      m_wr_q   <= 1'b0;
      m_addr_q <= '0;
      m_len_q  <= '0;
      beat_q   <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      m_req_q  <= m_req_d;
      m_wr_q   <= m_wr_d;
      m_addr_q <= m_addr_d;
      m_len_q  <= m_len_d;
      beat_q   <= beat_d;
      starve_q <= starve_d;
    end
  end

  // Outputs: handshakes routed to the owner only, and only in the matching phase
  always_comb begin
    bus.m_req     = m_req_q;
    bus.m_wr      = m_wr_q;
    bus.m_addr    = m_addr_q;
    bus.m_len     = m_len_q;
    bus.rdata     = bus.m_rdata;
    bus.m_wdata   = wdata_fwd;
    bus.m_wvalid  = 1'b0;
    bus.m_wlast   = 1'b0;
    bus.i_addr_ok = 1'b0;
    bus.d_addr_ok = 1'b0;
    bus.i_rvalid  = 1'b0;
    bus.i_rlast   = 1'b0;
    bus.d_rvalid  = 1'b0;
    bus.d_rlast   = 1'b0;
    bus.d_wready  = 1'b0;
    bus.d_bvalid  = 1'b0;

    case (state_q)
      StAddr: begin
        bus.i_addr_ok = bus.m_addr_ok && (owner_q == OwnI);
        bus.d_addr_ok = bus.m_addr_ok && (owner_q == OwnD);
      end
      StRdata: begin
        bus.i_rvalid = bus.m_rvalid && (owner_q == OwnI);
        bus.i_rlast  = bus.m_rvalid && bus.m_rlast && (owner_q == OwnI);
        bus.d_rvalid = bus.m_rvalid && (owner_q == OwnD);
        bus.d_rlast  = bus.m_rvalid && bus.m_rlast && (owner_q == OwnD);
      end
      StWdata: begin
        bus.m_wvalid = bus.d_wvalid;
        bus.m_wlast  = wlast;
        bus.d_wready = bus.m_wready;
      end
      StWresp: begin
        bus.d_bvalid = bus.m_bvalid;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: inputs change 1 time unit after the rising edge and
// outputs are sampled a further unit later, well away from the next edge.
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   acc;

  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32), .LEN_W(4)) bus ();

  mem_bus_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .LEN_W(4),
    .STARVE_LIMIT(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: observed no finish, required finish before 100000");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One read burst starting from an IDLE cycle whose request is already driven
  task automatic rd_txn(input bit is_i, input logic [31:0] addr, input logic [3:0] len,
                        input bit drop);
    chk("idle_m_req", bus.m_req, 0);
    tick();
    chk("addr_m_req", bus.m_req, 1);
    chk("addr_m_addr", bus.m_addr, addr);
    chk("addr_m_len", bus.m_len, len);
    chk("addr_m_wr", bus.m_wr, 0);
    bus.m_addr_ok = 1'b1;
    settle();
    chk("i_addr_ok", bus.i_addr_ok, is_i);
    chk("d_addr_ok", bus.d_addr_ok, !is_i);
    tick();
    bus.m_addr_ok = 1'b0;
    if (drop) begin
      if (is_i) bus.i_req = 1'b0;
      else      bus.d_req = 1'b0;
    end
    chk("rdata_m_req", bus.m_req, 0);
    for (int k = 0; k <= int'(len); k++) begin
      bus.m_rvalid = 1'b1;
      bus.m_rlast  = (k == int'(len));
      bus.m_rdata  = 32'hA500_0000 + k;
      settle();
      chk("i_rvalid", bus.i_rvalid, is_i);
      chk("d_rvalid", bus.d_rvalid, !is_i);
      chk("i_rlast", bus.i_rlast, is_i && (k == int'(len)));
      chk("d_rlast", bus.d_rlast, !is_i && (k == int'(len)));
      chk("rdata", bus.rdata, 32'hA500_0000 + k);
      tick();
    end
    bus.m_rvalid = 1'b0;
    bus.m_rlast  = 1'b0;
    settle();
  endtask

  initial begin
    reset         = 1'b1;
    bus.i_req     = 1'b0;
    bus.i_addr    = '0;
    bus.i_len     = '0;
    bus.d_req     = 1'b0;
    bus.d_wr      = 1'b0;
    bus.d_addr    = '0;
    bus.d_len     = '0;
    bus.d_wdata   = 32'hCAFE_0001;
    bus.d_wvalid  = 1'b0;
    bus.m_addr_ok = 1'b0;
    bus.m_rvalid  = 1'b0;
    bus.m_rlast   = 1'b0;
    bus.m_rdata   = 32'h1234_5678;
    bus.m_wready  = 1'b0;
    bus.m_bvalid  = 1'b0;

    // Reset state
    #2;
    chk("rst_m_req", bus.m_req, 0);
    chk("rst_m_wr", bus.m_wr, 0);
    chk("rst_m_addr", bus.m_addr, 0);
    chk("rst_m_len", bus.m_len, 0);
    chk("rst_m_wvalid", bus.m_wvalid, 0);
    chk("rst_m_wlast", bus.m_wlast, 0);
    chk("rst_i_addr_ok", bus.i_addr_ok, 0);
    chk("rst_d_addr_ok", bus.d_addr_ok, 0);
    chk("rst_d_wready", bus.d_wready, 0);
    chk("rst_d_bvalid", bus.d_bvalid, 0);
    chk("rst_rdata_pass", bus.rdata, 32'h1234_5678);
    chk("rst_wdata_pass", bus.m_wdata, 32'hCAFE_0001);
    tick();
    tick();
    reset = 1'b0;
    settle();

    // T1: ICache alone, 8-beat read
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h1fc0_0000;
    bus.i_len  = 4'd7;
    settle();
    chk("t1_no_early_ok", bus.i_addr_ok, 0);
    rd_txn(1'b1, 32'h1fc0_0000, 4'd7, 1'b1);
    chk("t1_back_idle", bus.m_req, 0);
    tick();
    chk("t1_stay_idle", bus.m_req, 0);

    // T2: simultaneous requests, DCache 4-beat write wins, then ICache
    bus.d_req    = 1'b1;
    bus.d_wr     = 1'b1;
    bus.d_addr   = 32'h8000_0100;
    bus.d_len    = 4'd3;
    bus.i_req    = 1'b1;
    bus.i_addr   = 32'h1fc0_0040;
    bus.i_len    = 4'd1;
    settle();
    tick();
    chk("t2_m_req", bus.m_req, 1);
    chk("t2_m_wr", bus.m_wr, 1);
    chk("t2_m_addr", bus.m_addr, 32'h8000_0100);
    chk("t2_m_len", bus.m_len, 3);
    bus.m_addr_ok = 1'b1;
    settle();
    chk("t2_d_addr_ok", bus.d_addr_ok, 1);
    chk("t2_i_addr_ok", bus.i_addr_ok, 0);
    tick();
    bus.m_addr_ok = 1'b0;
    bus.d_req     = 1'b0;
    bus.d_wvalid  = 1'b1;
    bus.m_wready  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.d_wdata = 32'hD0D0_0000 + k;
      settle();
      chk("t2_m_wvalid", bus.m_wvalid, 1);
      chk("t2_d_wready", bus.d_wready, 1);
      chk("t2_m_wlast", bus.m_wlast, (k == 3));
      chk("t2_m_wdata", bus.m_wdata, 32'hD0D0_0000 + k);
      tick();
    end
    bus.d_wvalid = 1'b0;
    settle();
    chk("t2_wresp_wready_stray", bus.d_wready, 0);
    chk("t2_wresp_wlast", bus.m_wlast, 0);
    chk("t2_no_early_bvalid", bus.d_bvalid, 0);
    bus.m_wready = 1'b0;
    bus.m_bvalid = 1'b1;
    settle();
    chk("t2_d_bvalid", bus.d_bvalid, 1);
    tick();
    bus.m_bvalid = 1'b0;
    bus.d_wr     = 1'b0;
    settle();
    chk("t2_bvalid_pulse", bus.d_bvalid, 0);
    rd_txn(1'b1, 32'h1fc0_0040, 4'd1, 1'b1);

    // T3: DCache held; each 1-beat D read costs the waiting ICache 3 cycles, so the
    // counter is at 0, 3, 6 for the first three arbitrations and saturated at 8 for the fourth.
    bus.d_req  = 1'b1;
    bus.d_wr   = 1'b0;
    bus.d_addr = 32'h8000_2000;
    bus.d_len  = 4'd0;
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h1fc0_0080;
    bus.i_len  = 4'd0;
    settle();
    rd_txn(1'b0, 32'h8000_2000, 4'd0, 1'b0);
    rd_txn(1'b0, 32'h8000_2000, 4'd0, 1'b0);
    rd_txn(1'b0, 32'h8000_2000, 4'd0, 1'b0);
    rd_txn(1'b1, 32'h1fc0_0080, 4'd0, 1'b1);
    rd_txn(1'b0, 32'h8000_2000, 4'd0, 1'b1);

    // T4: 4-beat write with m_wready toggling
    bus.d_req  = 1'b1;
    bus.d_wr   = 1'b1;
    bus.d_addr = 32'h8000_3000;
    bus.d_len  = 4'd3;
    settle();
    tick();
    chk("t4_m_wr", bus.m_wr, 1);
    bus.m_addr_ok = 1'b1;
    settle();
    chk("t4_d_addr_ok", bus.d_addr_ok, 1);
    tick();
    bus.m_addr_ok = 1'b0;
    bus.d_req     = 1'b0;
    bus.d_wvalid  = 1'b1;
    acc = 0;
    for (int c = 0; c < 7; c++) begin
      bus.m_wready = ((c % 2) == 0);
      bus.d_wdata  = 32'hBEEF_0000 + acc;
      settle();
      chk("t4_m_wvalid", bus.m_wvalid, 1);
      chk("t4_d_wready", bus.d_wready, ((c % 2) == 0));
      chk("t4_m_wlast", bus.m_wlast, (acc == 3));
      tick();
      if ((c % 2) == 0) acc++;
    end
    bus.d_wvalid = 1'b0;
    bus.m_wready = 1'b0;
    settle();
    chk("t4_wresp_wvalid", bus.m_wvalid, 0);
    bus.m_bvalid = 1'b1;
    settle();
    chk("t4_d_bvalid", bus.d_bvalid, 1);
    tick();
    bus.m_bvalid = 1'b0;
    bus.d_wr     = 1'b0;
    settle();

    // T5: stray downstream pulses while idle
    bus.m_rvalid = 1'b1;
    bus.m_rlast  = 1'b1;
    bus.m_bvalid = 1'b1;
    bus.m_wready = 1'b1;
    settle();
    chk("t5_i_rvalid", bus.i_rvalid, 0);
    chk("t5_d_rvalid", bus.d_rvalid, 0);
    chk("t5_i_rlast", bus.i_rlast, 0);
    chk("t5_d_rlast", bus.d_rlast, 0);
    chk("t5_d_bvalid", bus.d_bvalid, 0);
    chk("t5_d_wready", bus.d_wready, 0);
    tick();
    chk("t5_m_req", bus.m_req, 0);
    bus.m_rvalid = 1'b0;
    bus.m_rlast  = 1'b0;
    bus.m_bvalid = 1'b0;
    bus.m_wready = 1'b0;
    bus.d_req    = 1'b1;
    bus.d_addr   = 32'h8000_1000;
    bus.d_len    = 4'd1;
    settle();
    rd_txn(1'b0, 32'h8000_1000, 4'd1, 1'b1);

    // T6: reset during beat 3 of an 8-beat D read
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h8000_4000;
    bus.d_len  = 4'd7;
    settle();
    tick();
    bus.m_addr_ok = 1'b1;
    tick();
    bus.m_addr_ok = 1'b0;
    bus.d_req     = 1'b0;
    bus.m_rvalid  = 1'b1;
    tick();
    tick();
    settle();
    chk("t6_beat3_live", bus.d_rvalid, 1);
    reset = 1'b1;
    settle();
    chk("t6_rst_d_rvalid", bus.d_rvalid, 0);
    chk("t6_rst_m_req", bus.m_req, 0);
    chk("t6_rst_m_addr", bus.m_addr, 0);
    chk("t6_rst_m_len", bus.m_len, 0);
    tick();
    reset        = 1'b0;
    bus.m_rvalid = 1'b0;
    bus.d_req    = 1'b1;
    bus.d_addr   = 32'h8000_5000;
    bus.d_len    = 4'd0;
    settle();
    rd_txn(1'b0, 32'h8000_5000, 4'd0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
